// File: rtl/dma_axil_regslv.sv
// AXI4-Lite register slave for the SGDMA user side: ID, run control, channel status, scratch and W1C interrupts.
// Define AXIL_SLV_DECERR_EN to answer unmapped offsets with SLVERR instead of OKAY.
module dma_axil_regslv #(
    parameter logic [31:0] ID_VALUE = 32'h5347_0001
) (
    input  logic        usr_clk,
    input  logic        usr_rst_n,
    input  logic [31:0] s_axil_awaddr_i,
    input  logic [2:0]  s_axil_awprot_i,
    input  logic        s_axil_awvalid_i,
    output logic        s_axil_awready_o,
    input  logic [31:0] s_axil_wdata_i,
    input  logic [3:0]  s_axil_wstrb_i,
    input  logic        s_axil_wvalid_i,
    output logic        s_axil_wready_o,
    output logic        s_axil_bvalid_o,
    output logic [1:0]  s_axil_bresp_o,
    input  logic        s_axil_bready_i,
    input  logic [31:0] s_axil_araddr_i,
    input  logic [2:0]  s_axil_arprot_i,
    input  logic        s_axil_arvalid_i,
    output logic        s_axil_arready_o,
    output logic [31:0] s_axil_rdata_o,
    output logic [1:0]  s_axil_rresp_o,
    output logic        s_axil_rvalid_o,
    input  logic        s_axil_rready_i,
    output logic [1:0]  dma_regrw_run_o,
    input  logic [31:0] h2c0_chn_stts_i,
    input  logic [31:0] c2h0_chn_stts_i,
    input  logic        c2h0_done_i,
    input  logic        h2c0_done_i,
    output logic        irq_o
);

    localparam logic [13:0] IDX_ID       = 14'd0;
    localparam logic [13:0] IDX_CTRL     = 14'd1;
    localparam logic [13:0] IDX_H2C_STTS = 14'd2;
    localparam logic [13:0] IDX_C2H_STTS = 14'd3;
    localparam logic [13:0] IDX_SCRATCH  = 14'd4;
    localparam logic [13:0] IDX_IRQ_PEND = 14'd5;
    localparam logic [13:0] IDX_IRQ_EN   = 14'd6;

    logic        aw_hold_q, aw_hold_d;
    logic [13:0] aw_idx_q, aw_idx_d;
    logic        w_hold_q, w_hold_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] scratch_q, scratch_d;
    logic [1:0]  irq_pend_q, irq_pend_d;
    logic [1:0]  irq_en_q, irq_en_d;
    logic        irq_q, irq_d;

    logic        aw_fire, w_fire, ar_fire, b_hs, r_hs, wr_commit;
    logic [13:0] wr_idx, rd_idx;
    logic [31:0] wr_data, rd_word;
    logic [3:0]  wr_strb;
    logic [1:0]  pend_clr;
    logic [1:0]  wr_resp, rd_resp;

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_awaddr_i[31:16],
                         s_axil_awaddr_i[1:0], s_axil_araddr_i[31:16], s_axil_araddr_i[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign s_axil_awready_o = ~aw_hold_q & ~bvalid_q;
    assign s_axil_wready_o  = ~w_hold_q & ~bvalid_q;
    assign s_axil_arready_o = ~rvalid_q;
    assign s_axil_bvalid_o  = bvalid_q;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;
    assign dma_regrw_run_o  = ctrl_q;
    assign irq_o            = irq_q;

    always_comb begin
        aw_fire   = s_axil_awvalid_i & s_axil_awready_o;
        w_fire    = s_axil_wvalid_i & s_axil_wready_o;
        ar_fire   = s_axil_arvalid_i & s_axil_arready_o;
        b_hs      = bvalid_q & s_axil_bready_i;
        r_hs      = rvalid_q & s_axil_rready_i;
        wr_idx    = aw_hold_q ? aw_idx_q : s_axil_awaddr_i[15:2];
        wr_data   = w_hold_q ? w_data_q : s_axil_wdata_i;
        wr_strb   = w_hold_q ? w_strb_q : s_axil_wstrb_i;
        // Holds stay set after commit so the same write cannot re-commit before B completes.
        wr_commit = (aw_hold_q | aw_fire) & (w_hold_q | w_fire) & ~bvalid_q;
        rd_idx    = s_axil_araddr_i[15:2];
`ifdef AXIL_SLV_DECERR_EN
        wr_resp   = (wr_idx > IDX_IRQ_EN) ? 2'b10 : 2'b00;
        rd_resp   = (rd_idx > IDX_IRQ_EN) ? 2'b10 : 2'b00;
`else
        wr_resp   = 2'b00;
        rd_resp   = 2'b00;
`endif
    end

    always_comb begin
        rd_word = 32'h0;
        case (rd_idx)
            IDX_ID:       rd_word = ID_VALUE;
            IDX_CTRL:     rd_word = {30'h0, ctrl_q};
            IDX_H2C_STTS: rd_word = h2c0_chn_stts_i;
            IDX_C2H_STTS: rd_word = c2h0_chn_stts_i;
            IDX_SCRATCH:  rd_word = scratch_q;
            IDX_IRQ_PEND: rd_word = {30'h0, irq_pend_q};
            IDX_IRQ_EN:   rd_word = {30'h0, irq_en_q};
            default:      rd_word = 32'h0;
        endcase
    end

    always_comb begin
        aw_hold_d = aw_hold_q;
        aw_idx_d  = aw_idx_q;
        w_hold_d  = w_hold_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        irq_en_d  = irq_en_q;
        pend_clr  = 2'b00;
        if (aw_fire) begin
            aw_hold_d = 1'b1;
            aw_idx_d  = s_axil_awaddr_i[15:2];
        end
        if (w_fire) begin
            w_hold_d = 1'b1;
            w_data_d = s_axil_wdata_i;
            w_strb_d = s_axil_wstrb_i;
        end
        if (b_hs) begin
            aw_hold_d = 1'b0;
            w_hold_d  = 1'b0;
            bvalid_d  = 1'b0;
        end
        if (wr_commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
            case (wr_idx)
                IDX_CTRL:     if (wr_strb[0]) ctrl_d = wr_data[1:0];
                IDX_SCRATCH:  scratch_d = merge_bytes(scratch_q, wr_data, wr_strb);
                IDX_IRQ_PEND: if (wr_strb[0]) pend_clr = wr_data[1:0];
                IDX_IRQ_EN:   if (wr_strb[0]) irq_en_d = wr_data[1:0];
                default:      ;
            endcase
        end
        // A done pulse landing on the same edge as a W1C must not be lost.
        irq_pend_d = (irq_pend_q & ~pend_clr) | {h2c0_done_i, c2h0_done_i};
        irq_d      = |(irq_pend_q & irq_en_q);
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (r_hs) rvalid_d = 1'b0;
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_resp;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            aw_hold_q  <= 1'b0;
            aw_idx_q   <= 14'h0;
            w_hold_q   <= 1'b0;
            w_data_q   <= 32'h0;
            w_strb_q   <= 4'h0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            rresp_q    <= 2'b00;
            ctrl_q     <= 2'b00;
            scratch_q  <= 32'h0;
            irq_pend_q <= 2'b00;
            irq_en_q   <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            aw_hold_q  <= aw_hold_d;
            aw_idx_q   <= aw_idx_d;
            w_hold_q   <= w_hold_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            irq_pend_q <= irq_pend_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_dma_axil_regslv.sv
// Directed self-checking bench for dma_axil_regslv; inputs change and outputs are sampled on the falling clock edge.
module tb_dma_axil_regslv;

    logic        usr_clk = 1'b0;
    logic        usr_rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [1:0]  run;
    logic [31:0] h2c_stts = '0;
    logic [31:0] c2h_stts = '0;
    logic        c2h_done = 1'b0;
    logic        h2c_done = 1'b0;
    logic        irq;

    int nvec = 0;
    int nerr = 0;

`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    always #5 usr_clk = ~usr_clk;

    dma_axil_regslv dut (
        .usr_clk(usr_clk), .usr_rst_n(usr_rst_n),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot),
        .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb),
        .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
        .s_axil_bvalid_o(bvalid), .s_axil_bresp_o(bresp), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot),
        .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp),
        .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
        .dma_regrw_run_o(run),
        .h2c0_chn_stts_i(h2c_stts), .c2h0_chn_stts_i(c2h_stts),
        .c2h0_done_i(c2h_done), .h2c0_done_i(h2c_done),
        .irq_o(irq)
    );

    // Issues AW and W together and waits for the B response; ends one cycle after B is seen.
    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_pend, w_pend, fa, fw, got;
        @(negedge usr_clk);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; got = 1'b0; resp = 2'b11;
        for (int i = 0; i < 20 && (aw_pend || w_pend); i++) begin
            fa = awvalid && awready;
            fw = wvalid && wready;
            @(negedge usr_clk);
            if (fa) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (fw) begin wvalid = 1'b0; w_pend = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin got = 1'b1; resp = bresp; end
            @(negedge usr_clk);
        end
        ok = got;
    endtask

    // Issues AR and returns data, response and cycles from AR edge to first rvalid sample.
    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic [1:0] resp, output int lat, output bit ok);
        bit got, fa;
        @(negedge usr_clk);
        araddr = addr; arvalid = 1'b1;
        fa = 1'b0; got = 1'b0; lat = 0; data = '0; resp = 2'b11;
        for (int i = 0; i < 20 && !fa; i++) begin
            fa = arready;
            @(negedge usr_clk);
        end
        arvalid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin got = 1'b1; data = rdata; resp = rresp; end
            else lat++;
            @(negedge usr_clk);
        end
        ok = fa && got;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        usr_rst_n = 1'b0;
        repeat (3) @(negedge usr_clk);
        nvec++; if ({awready, wready, arready} !== 3'b111) begin nerr++; $display("[TB] FAIL reset_ready got=%b exp=111", {awready, wready, arready}); end
        nvec++; if ({bvalid, rvalid, irq} !== 3'b000) begin nerr++; $display("[TB] FAIL reset_valid got=%b exp=000", {bvalid, rvalid, irq}); end
        nvec++; if ({bresp, rresp, run} !== 6'b0) begin nerr++; $display("[TB] FAIL reset_resp_run got=%b exp=000000", {bresp, rresp, run}); end
        nvec++; if (rdata !== 32'h0) begin nerr++; $display("[TB] FAIL reset_rdata got=%h exp=00000000", rdata); end
        usr_rst_n = 1'b1;
        axil_read(32'h0, d, r, lat, ok);
        nvec++; if (!ok) begin nerr++; $display("[TB] FAIL id_read_timeout got=timeout exp=response"); end
        nvec++; if (d !== 32'h5347_0001) begin nerr++; $display("[TB] FAIL id_rdata got=%h exp=53470001", d); end
        nvec++; if (r !== 2'b00) begin nerr++; $display("[TB] FAIL id_rresp got=%b exp=00", r); end
        nvec++; if (lat !== 0) begin nerr++; $display("[TB] FAIL id_latency got=%0d exp=0 extra cycles", lat); end
    endtask

    task automatic test_ctrl_split();
        @(negedge usr_clk);
        wdata = 32'h3; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge usr_clk);
        wvalid = 1'b0;
        nvec++; if ({wready, awready} !== 2'b01) begin nerr++; $display("[TB] FAIL ctrl_w_held got=%b exp=01", {wready, awready}); end
        @(negedge usr_clk);
        awaddr = 32'h4; awvalid = 1'b1;
        nvec++; if (bvalid !== 1'b0) begin nerr++; $display("[TB] FAIL ctrl_no_early_b got=%b exp=0", bvalid); end
        @(negedge usr_clk);
        awvalid = 1'b0;
        nvec++; if (bvalid !== 1'b1) begin nerr++; $display("[TB] FAIL ctrl_bvalid got=%b exp=1", bvalid); end
        nvec++; if (run !== 2'b11) begin nerr++; $display("[TB] FAIL ctrl_run got=%b exp=11", run); end
        @(negedge usr_clk);
        nvec++; if ({bvalid, awready, wready} !== 3'b011) begin nerr++; $display("[TB] FAIL ctrl_b_done got=%b exp=011", {bvalid, awready, wready}); end
    endtask

    task automatic test_scratch_strobe();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        axil_write(32'h10, 32'hAABB_CCDD, 4'hF, r, ok);
        nvec++; if (!ok || r !== 2'b00) begin nerr++; $display("[TB] FAIL scratch_wr1 got=ok%0d resp%b exp=ok1 resp00", ok, r); end
        @(negedge usr_clk);
        bready = 1'b0;
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1;
        @(negedge usr_clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge usr_clk);
            nvec++; if ({bvalid, awready, wready} !== 3'b100) begin nerr++; $display("[TB] FAIL b_stall_%0d got=%b exp=100", i, {bvalid, awready, wready}); end
        end
        bready = 1'b1;
        @(negedge usr_clk);
        nvec++; if (bvalid !== 1'b0) begin nerr++; $display("[TB] FAIL b_release got=%b exp=0", bvalid); end
        axil_read(32'h10, d, r, lat, ok);
        nvec++; if (d !== 32'hAA22_CC44) begin nerr++; $display("[TB] FAIL scratch_strobe got=%h exp=aa22cc44", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        @(negedge usr_clk);
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h5555_0000; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h10; arvalid = 1'b1;
        @(negedge usr_clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        nvec++; if ({bvalid, rvalid} !== 2'b11) begin nerr++; $display("[TB] FAIL concur_valids got=%b exp=11", {bvalid, rvalid}); end
        nvec++; if (rdata !== 32'hAA22_CC44) begin nerr++; $display("[TB] FAIL concur_old_value got=%h exp=aa22cc44", rdata); end
        @(negedge usr_clk);
        axil_read(32'h10, d, r, lat, ok);
        nvec++; if (d !== 32'h5555_0000) begin nerr++; $display("[TB] FAIL concur_new_value got=%h exp=55550000", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        axil_write(32'h18, 32'h1, 4'hF, r, ok);
        @(negedge usr_clk);
        c2h_done = 1'b1;
        @(negedge usr_clk);
        c2h_done = 1'b0;
        nvec++; if (irq !== 1'b0) begin nerr++; $display("[TB] FAIL irq_lag got=%b exp=0", irq); end
        @(negedge usr_clk);
        nvec++; if (irq !== 1'b1) begin nerr++; $display("[TB] FAIL irq_assert got=%b exp=1", irq); end
        axil_read(32'h14, d, r, lat, ok);
        nvec++; if (d !== 32'h1) begin nerr++; $display("[TB] FAIL pend_set got=%h exp=00000001", d); end
        @(negedge usr_clk);
        awaddr = 32'h14; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'h1; wvalid = 1'b1;
        c2h_done = 1'b1;
        @(negedge usr_clk);
        awvalid = 1'b0; wvalid = 1'b0; c2h_done = 1'b0;
        @(negedge usr_clk);
        axil_read(32'h14, d, r, lat, ok);
        nvec++; if (d !== 32'h1) begin nerr++; $display("[TB] FAIL pend_set_wins got=%h exp=00000001", d); end
        axil_write(32'h14, 32'h1, 4'h1, r, ok);
        nvec++; if (irq !== 1'b0) begin nerr++; $display("[TB] FAIL irq_cleared got=%b exp=0", irq); end
        axil_read(32'h14, d, r, lat, ok);
        nvec++; if (d !== 32'h0) begin nerr++; $display("[TB] FAIL pend_cleared got=%h exp=00000000", d); end
        @(negedge usr_clk);
        h2c_done = 1'b1;
        @(negedge usr_clk);
        h2c_done = 1'b0;
        repeat (2) @(negedge usr_clk);
        nvec++; if (irq !== 1'b0) begin nerr++; $display("[TB] FAIL irq_masked got=%b exp=0", irq); end
        axil_read(32'h14, d, r, lat, ok);
        nvec++; if (d !== 32'h2) begin nerr++; $display("[TB] FAIL pend_h2c got=%h exp=00000002", d); end
    endtask

    task automatic test_status_hold();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        c2h_stts = 32'h0000_1234;
        h2c_stts = 32'hCAFE_0042;
        @(negedge usr_clk);
        rready = 1'b0;
        araddr = 32'hC; arvalid = 1'b1;
        @(negedge usr_clk);
        arvalid = 1'b0;
        c2h_stts = 32'hFFFF_FFFF;
        nvec++; if ({rvalid, arready} !== 2'b10) begin nerr++; $display("[TB] FAIL stts_rvalid got=%b exp=10", {rvalid, arready}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge usr_clk);
            nvec++; if (rdata !== 32'h0000_1234 || rvalid !== 1'b1) begin nerr++; $display("[TB] FAIL stts_hold_%0d got=%h/%b exp=00001234/1", i, rdata, rvalid); end
        end
        rready = 1'b1;
        @(negedge usr_clk);
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("[TB] FAIL stts_release got=%b exp=0", rvalid); end
        axil_read(32'h8, d, r, lat, ok);
        nvec++; if (d !== 32'hCAFE_0042) begin nerr++; $display("[TB] FAIL h2c_stts got=%h exp=cafe0042", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        axil_read(32'h40, d, r, lat, ok);
        nvec++; if (d !== 32'h0 || r !== UNMAP_RESP) begin nerr++; $display("[TB] FAIL unmap_rd_40 got=%h/%b exp=00000000/%b", d, r, UNMAP_RESP); end
        axil_read(32'h1C, d, r, lat, ok);
        nvec++; if (d !== 32'h0 || r !== UNMAP_RESP) begin nerr++; $display("[TB] FAIL unmap_rd_1c got=%h/%b exp=00000000/%b", d, r, UNMAP_RESP); end
        axil_read(32'h18, d, r, lat, ok);
        nvec++; if (d !== 32'h1 || r !== 2'b00) begin nerr++; $display("[TB] FAIL irq_en_rd got=%h/%b exp=00000001/00", d, r); end
        axil_write(32'h40, 32'hDEAD_BEEF, 4'hF, r, ok);
        nvec++; if (!ok || r !== UNMAP_RESP) begin nerr++; $display("[TB] FAIL unmap_wr_resp got=ok%0d/%b exp=ok1/%b", ok, r, UNMAP_RESP); end
        axil_write(32'h08, 32'hDEAD_BEEF, 4'hF, r, ok);
        nvec++; if (!ok || r !== 2'b00) begin nerr++; $display("[TB] FAIL ro_wr_resp got=ok%0d/%b exp=ok1/00", ok, r); end
        axil_read(32'h10, d, r, lat, ok);
        nvec++; if (d !== 32'h5555_0000) begin nerr++; $display("[TB] FAIL unmap_no_effect got=%h exp=55550000", d); end
    endtask

    task automatic test_reset_midflight();
        @(negedge usr_clk);
        bready = 1'b0;
        awaddr = 32'h4; awvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge usr_clk);
        awvalid = 1'b0; wvalid = 1'b0;
        usr_rst_n = 1'b0;
        #1;
        nvec++; if ({bvalid, awready, run} !== 4'b0100) begin nerr++; $display("[TB] FAIL midrst got=%b exp=0100", {bvalid, awready, run}); end
        @(negedge usr_clk);
        usr_rst_n = 1'b1; bready = 1'b1;
        @(negedge usr_clk);
    endtask

    initial begin
        test_reset();
        test_ctrl_split();
        test_scratch_strobe();
        test_back_to_back();
        test_irq();
        test_status_hold();
        test_unmapped();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
